// File: rtl/fetch_module.sv
// fetch_module: MIPS instruction-fetch stage; owns the PC and reads one word at a time from instruction memory.
// Latency: outputs register on the edge that accepts a memory response, so 1 instr/cycle with zero-wait memory.
// Backpressure: stall_in freezes the outputs; a response landing during stall parks in a 1-entry skid buffer.
module fetch_module #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_in,
  input  logic        redirect_in,
  input  logic [31:0] redirect_addr_in,
  output logic        imem_req_out,
  output logic [31:0] imem_addr_out,
  input  logic        imem_valid_in,
  input  logic [31:0] imem_data_in,
  output logic [31:0] instr_out,
  output logic [31:0] pc_seq_out,
  output logic [31:0] pc_seq_2_out,
  output logic        instr_valid_out
);

  // ISSUE: fresh request; WAIT: request outstanding; HOLD: skid buffer full,
  // no request; DROP: stale request outstanding after a redirect.
  typedef enum logic [1:0] {
    ST_ISSUE = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DROP  = 2'd3
  } state_t;

  // What the decode-facing registers load this cycle.
  typedef enum logic [1:0] {
    OUT_KEEP   = 2'd0,
    OUT_BUBBLE = 2'd1,
    OUT_MEM    = 2'd2,
    OUT_SKID   = 2'd3
  } out_sel_t;

  state_t      state, state_nxt;
  out_sel_t    out_sel;
  logic [31:0] pc, pc_nxt, pc_plus4;
  logic [31:0] redir_tgt, drop_tgt;
  logic        drop_tgt_ld;
  logic [31:0] skid_instr, skid_pc_seq;
  logic        skid_ld;
  logic        post_reset;
  logic        resp;

  // pc+4 wraps silently at the top of the address space.
  assign pc_plus4  = pc + 32'd4;
  assign redir_tgt = {redirect_addr_in[31:2], 2'b00};
  assign imem_addr_out = pc;

  // A response only completes our request when we are asking, and never in
  // the first cycle after reset (it may belong to an abandoned transaction).
  assign resp = imem_valid_in && imem_req_out && !post_reset;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_ISSUE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and datapath control; redirect outranks stall and any same-cycle response.
  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    out_sel     = OUT_KEEP;
    skid_ld     = 1'b0;
    drop_tgt_ld = 1'b0;
    if (redirect_in) begin
      out_sel = OUT_BUBBLE;
      if (imem_req_out && !resp) begin
        // Request still in flight: let it drain, then jump.
        state_nxt   = ST_DROP;
        drop_tgt_ld = 1'b1;
      end else begin
        state_nxt = ST_ISSUE;
        pc_nxt    = redir_tgt;
      end
    end else begin
      case (state)
        ST_ISSUE, ST_WAIT: begin
          if (resp) begin
            pc_nxt = pc_plus4;
            if (stall_in) begin
              skid_ld   = 1'b1;
              state_nxt = ST_HOLD;
            end else begin
              out_sel   = OUT_MEM;
              state_nxt = ST_ISSUE;
            end
          end else begin
            state_nxt = ST_WAIT;
            if (!stall_in) out_sel = OUT_BUBBLE;
          end
        end
        ST_HOLD: begin
          if (!stall_in) begin
            out_sel   = OUT_SKID;
            state_nxt = ST_ISSUE;
          end
        end
        ST_DROP: begin
          if (!stall_in) out_sel = OUT_BUBBLE;
          if (resp) begin
            pc_nxt    = drop_tgt;
            state_nxt = ST_ISSUE;
          end
        end
        default: state_nxt = ST_ISSUE;
      endcase
    end
  end

  // Memory request is idle only while the skid buffer is occupied.
  always_comb begin
    imem_req_out = (state != ST_HOLD);
  end

  // PC, skid buffer, pending redirect target and post-reset guard.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= {RESET_PC[31:2], 2'b00};
      skid_instr  <= NOP;
      skid_pc_seq <= 32'd0;
      drop_tgt    <= 32'd0;
      post_reset  <= 1'b1;
    end else begin
      pc         <= pc_nxt;
      post_reset <= 1'b0;
      if (skid_ld) begin
        skid_instr  <= imem_data_in;
        skid_pc_seq <= pc_plus4;
      end
      if (drop_tgt_ld) drop_tgt <= redir_tgt;
    end
  end

  // Decode-facing output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_out       <= NOP;
      pc_seq_out      <= 32'd0;
      pc_seq_2_out    <= 32'd0;
      instr_valid_out <= 1'b0;
    end else begin
      case (out_sel)
        OUT_MEM: begin
          instr_out       <= imem_data_in;
          pc_seq_out      <= pc_plus4;
          pc_seq_2_out    <= pc_plus4;
          instr_valid_out <= 1'b1;
        end
        OUT_SKID: begin
          instr_out       <= skid_instr;
          pc_seq_out      <= skid_pc_seq;
          pc_seq_2_out    <= skid_pc_seq;
          instr_valid_out <= 1'b1;
        end
        OUT_BUBBLE: begin
          instr_out       <= NOP;
          instr_valid_out <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_module.sv
// tb_fetch_module: directed test of the fetch stage against a simple latency-programmable memory model.
// Latency: each step drives one cycle of inputs, clocks once, and samples outputs 1 ns after the edge.
// Backpressure: stall/redirect are driven per step; memory responds after 'lat' cycles of req.
module tb_fetch_module;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall_in = 1'b0;
  logic        redirect_in = 1'b0;
  logic [31:0] redirect_addr_in = 32'd0;
  logic        imem_req_out;
  logic [31:0] imem_addr_out;
  logic        imem_valid_in = 1'b0;
  logic [31:0] imem_data_in = 32'd0;
  logic [31:0] instr_out;
  logic [31:0] pc_seq_out;
  logic [31:0] pc_seq_2_out;
  logic        instr_valid_out;

  int n_cmp = 0;
  int n_mis = 0;
  int lat   = 1;
  int cnt   = 0;

  fetch_module dut (
    .clk              (clk),
    .reset            (reset),
    .stall_in         (stall_in),
    .redirect_in      (redirect_in),
    .redirect_addr_in (redirect_addr_in),
    .imem_req_out     (imem_req_out),
    .imem_addr_out    (imem_addr_out),
    .imem_valid_in    (imem_valid_in),
    .imem_data_in     (imem_data_in),
    .instr_out        (instr_out),
    .pc_seq_out       (pc_seq_out),
    .pc_seq_2_out     (pc_seq_2_out),
    .instr_valid_out  (instr_valid_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [31:0] instr, input logic [31:0] seq,
                          input logic vld);
    chk({tag, ".instr"}, instr_out, instr);
    chk({tag, ".pc_seq"}, pc_seq_out, seq);
    chk({tag, ".pc_seq_2"}, pc_seq_2_out, seq);
    chk({tag, ".vld"}, 32'(instr_valid_out), 32'(vld));
  endtask

  task automatic chk_req(input string tag, input logic req, input logic [31:0] addr);
    chk({tag, ".req"}, 32'(imem_req_out), 32'(req));
    if (req) chk({tag, ".addr"}, imem_addr_out, addr);
  endtask

  // Memory model: the word at address a is ~a; answers on the lat-th cycle of req.
  task automatic drive_mem();
    if (imem_req_out === 1'b1) begin
      cnt++;
      if (cnt >= lat) begin
        imem_valid_in = 1'b1;
        imem_data_in  = ~imem_addr_out;
        cnt = 0;
      end else begin
        imem_valid_in = 1'b0;
        imem_data_in  = 32'h0BAD_0BAD;
      end
    end else begin
      imem_valid_in = 1'b0;
      imem_data_in  = 32'h0BAD_0BAD;
      cnt = 0;
    end
  endtask

  task automatic step_raw(input logic st, input logic rd, input logic [31:0] ra);
    stall_in         = st;
    redirect_in      = rd;
    redirect_addr_in = ra;
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic st, input logic rd, input logic [31:0] ra);
    drive_mem();
    step_raw(st, rd, ra);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    // Reset state.
    reset = 1'b1;
    imem_valid_in = 1'b0;
    step_raw(0, 0, 0);
    step_raw(0, 0, 0);
    chk_outs("rst", 32'h0, 32'h0, 1'b0);
    chk_req("rst", 1'b1, 32'h0);
    reset = 1'b0;
    lat = 1; cnt = 0;

    // Zero-wait stream; the response in the first post-reset cycle is ignored.
    step(0, 0, 0);
    chk_outs("zw0", 32'h0, 32'h0, 1'b0);
    chk_req("zw0", 1'b1, 32'h0);
    step(0, 0, 0);
    chk_outs("zw1", 32'hFFFF_FFFF, 32'h4, 1'b1);
    chk_req("zw1", 1'b1, 32'h4);
    step(0, 0, 0);
    chk_outs("zw2", 32'hFFFF_FFFB, 32'h8, 1'b1);
    chk_req("zw2", 1'b1, 32'h8);
    step(0, 0, 0);
    chk_outs("zw3", 32'hFFFF_FFF7, 32'hC, 1'b1);
    chk_req("zw3", 1'b1, 32'hC);

    // Stall for 4 cycles: outputs frozen on instr @0x8, @0xC parked.
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0);
      chk_outs($sformatf("stall%0d", i), 32'hFFFF_FFF7, 32'hC, 1'b1);
      chk_req($sformatf("stall%0d", i), 1'b0, 32'h0);
    end
    step(0, 0, 0);
    chk_outs("unstall", 32'hFFFF_FFF3, 32'h10, 1'b1);
    chk_req("unstall", 1'b1, 32'h10);

    // Three-cycle memory: address held, one instr per 3 cycles.
    lat = 3;
    step(0, 0, 0);
    chk_outs("lat3a", 32'h0, 32'h10, 1'b0);
    chk_req("lat3a", 1'b1, 32'h10);
    step(0, 0, 0);
    chk_req("lat3b", 1'b1, 32'h10);
    chk("lat3b.vld", 32'(instr_valid_out), 32'd0);
    step(0, 0, 0);
    chk_outs("lat3c", 32'hFFFF_FFEF, 32'h14, 1'b1);
    chk_req("lat3c", 1'b1, 32'h14);
    step(0, 0, 0);
    chk("lat3d.vld", 32'(instr_valid_out), 32'd0);
    step(0, 0, 0);
    step(0, 0, 0);
    chk_outs("lat3e", 32'hFFFF_FFEB, 32'h18, 1'b1);
    chk_req("lat3e", 1'b1, 32'h18);

    // Redirect (unaligned target) while the request @0x18 is pending.
    step(0, 1, 32'h0000_0403);
    chk_outs("drop0", 32'h0, 32'h18, 1'b0);
    chk_req("drop0", 1'b1, 32'h18);
    step(0, 0, 0);
    chk("drop1.vld", 32'(instr_valid_out), 32'd0);
    step(0, 0, 0);
    chk("drop2.vld", 32'(instr_valid_out), 32'd0);
    chk("drop2.instr", instr_out, 32'h0);
    chk_req("drop2", 1'b1, 32'h400);
    lat = 1;
    step(0, 0, 0);
    chk_outs("tgt", 32'hFFFF_FBFF, 32'h404, 1'b1);
    chk_req("tgt", 1'b1, 32'h404);

    // Redirect + stall while holding a buffered instr: buffer is discarded.
    step(1, 0, 0);
    chk_outs("hold", 32'hFFFF_FBFF, 32'h404, 1'b1);
    chk_req("hold", 1'b0, 32'h0);
    step(1, 1, 32'h800);
    chk("hrd.vld", 32'(instr_valid_out), 32'd0);
    chk_req("hrd", 1'b1, 32'h800);
    step(0, 0, 0);
    chk_outs("hrd2", 32'hFFFF_F7FF, 32'h804, 1'b1);

    // Redirect with a same-cycle response, to the top word; then pc+4 wraps.
    step(0, 1, 32'hFFFF_FFFE);
    chk_outs("rsame", 32'h0, 32'h804, 1'b0);
    chk_req("rsame", 1'b1, 32'hFFFF_FFFC);
    step(0, 0, 0);
    chk_outs("wrap", 32'h0000_0003, 32'h0, 1'b1);
    chk_req("wrap", 1'b1, 32'h0);

    // Two redirects while a request drains: the second target wins.
    lat = 3;
    step(0, 1, 32'h100);
    step(0, 1, 32'h200);
    chk_req("redir2a", 1'b1, 32'h0);
    step(0, 0, 0);
    chk_req("redir2b", 1'b1, 32'h200);
    chk("redir2b.vld", 32'(instr_valid_out), 32'd0);

    // Reset during WAIT; a late response right after reset is ignored.
    step(0, 0, 0);
    chk_req("wait", 1'b1, 32'h200);
    reset = 1'b1;
    imem_valid_in = 1'b0;
    step_raw(0, 0, 0);
    chk_outs("rst2", 32'h0, 32'h0, 1'b0);
    chk_req("rst2", 1'b1, 32'h0);
    reset = 1'b0;
    imem_valid_in = 1'b1;
    imem_data_in  = 32'hDEAD_BEEF;
    step_raw(0, 0, 0);
    chk_outs("late", 32'h0, 32'h0, 1'b0);
    chk_req("late", 1'b1, 32'h0);
    lat = 1; cnt = 0;
    step(0, 0, 0);
    chk_outs("resume", 32'hFFFF_FFFF, 32'h4, 1'b1);
    chk_req("resume", 1'b1, 32'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
